// File: rtl/adc_uart_reporter.sv
// Periodic ADC reporter: samples a 16-bit value on a timer tick, converts it to five
// decimal digits by double-dabble, and sends them as ASCII plus CR LF over UART 8N1.
module adc_uart_reporter #(
  parameter int unsigned CLK_FREQ      = 100_000_000,
  parameter int unsigned BAUD          = 115200,
  parameter int unsigned REPORT_PERIOD = 10_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] adc_data,
  output logic        tx,
  output logic        busy,
  output logic [7:0]  overrun_count
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned TIMER_W      = (REPORT_PERIOD > 1) ? $clog2(REPORT_PERIOD) : 1;
  localparam int unsigned BIN_W        = 16;
  localparam int unsigned BCD_W        = 20;

  typedef enum logic [1:0] {IDLE, CONVERT, SEND} state_t;

  state_t             state, state_next;
  logic [TIMER_W-1:0] timer;
  logic [BIN_W-1:0]   bin;
  logic [BCD_W-1:0]   bcd;
  logic [3:0]         iter;
  logic [9:0]         sh;
  logic [BAUD_W-1:0]  baud_cnt;
  logic [3:0]         bit_cnt;
  logic [2:0]         byte_idx;
  logic               loaded;

  logic tick_c, accept_c, overrun_c, dabble_c, load_c;
  logic bit_end_c, frame_done_c, next_byte_c;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
  function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < 5; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Byte order: most significant digit first, then CR, LF.
  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [BCD_W-1:0] d);
    logic [7:0] b;
    case (idx)
      3'd0:    b = 8'h30 | {4'h0, d[19:16]};
      3'd1:    b = 8'h30 | {4'h0, d[15:12]};
      3'd2:    b = 8'h30 | {4'h0, d[11:8]};
      3'd3:    b = 8'h30 | {4'h0, d[7:4]};
      3'd4:    b = 8'h30 | {4'h0, d[3:0]};
      3'd5:    b = 8'h0D;
      default: b = 8'h0A;
    endcase
    return b;
  endfunction

  assign tick_c = enable && (timer == TIMER_W'(REPORT_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (!reset)                timer <= '0;
    else if (!enable || tick_c) timer <= '0;
    else                       timer <= timer + TIMER_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tick_c) state_next = CONVERT;
      CONVERT: if (iter == 4'd15) state_next = SEND;
      SEND:    if (frame_done_c) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    accept_c     = 1'b0;
    overrun_c    = 1'b0;
    dabble_c     = 1'b0;
    load_c       = 1'b0;
    bit_end_c    = 1'b0;
    frame_done_c = 1'b0;
    next_byte_c  = 1'b0;
    accept_c     = tick_c && (state == IDLE);
    overrun_c    = tick_c && (state != IDLE);
    dabble_c     = (state == CONVERT);
    load_c       = (state == SEND) && !loaded;
    bit_end_c    = (state == SEND) && loaded && (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    frame_done_c = bit_end_c && (bit_cnt == 4'd9) && (byte_idx == 3'd6);
    next_byte_c  = bit_end_c && (bit_cnt == 4'd9) && (byte_idx != 3'd6);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx            <= 1'b1;
      busy          <= 1'b0;
      overrun_count <= '0;
      bin           <= '0;
      bcd           <= '0;
      iter          <= '0;
      sh            <= '1;
      baud_cnt      <= '0;
      bit_cnt       <= '0;
      byte_idx      <= '0;
      loaded        <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      if (overrun_c && overrun_count != 8'hFF) overrun_count <= overrun_count + 8'd1;
      if (accept_c) begin
        bin    <= adc_data;
        bcd    <= '0;
        iter   <= '0;
        loaded <= 1'b0;
      end
      if (dabble_c) begin
        {bcd, bin} <= {dabble_adj(bcd), bin} << 1;
        iter       <= iter + 4'd1;
      end
      if (load_c) begin
        sh       <= {1'b1, frame_byte(3'd0, bcd), 1'b0};
        tx       <= 1'b0;
        loaded   <= 1'b1;
        byte_idx <= '0;
        bit_cnt  <= '0;
        baud_cnt <= '0;
      end
      // Stop bit of one byte flows straight into the start bit of the next.
      if ((state == SEND) && loaded) begin
        if (bit_end_c) begin
          baud_cnt <= '0;
          if (frame_done_c) begin
            tx     <= 1'b1;
            loaded <= 1'b0;
          end else if (next_byte_c) begin
            byte_idx <= byte_idx + 3'd1;
            sh       <= {1'b1, frame_byte(byte_idx + 3'd1, bcd), 1'b0};
            tx       <= 1'b0;
            bit_cnt  <= '0;
          end else begin
            sh      <= {1'b1, sh[9:1]};
            tx      <= sh[1];
            bit_cnt <= bit_cnt + 4'd1;
          end
        end else begin
          baud_cnt <= baud_cnt + BAUD_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_uart_reporter.sv
// Bench for adc_uart_reporter: decodes UART frames against a table of expected bytes,
// plus reset, enable and overrun sequences on a second, short-period instance.
module tb_adc_uart_reporter;

  logic        clk = 1'b0;
  logic        reset_a, enable_a, tx_a, busy_a;
  logic [15:0] adc_a;
  logic [7:0]  ovr_a;
  logic        reset_b, enable_b, tx_b, busy_b;
  logic [15:0] adc_b;
  logic [7:0]  ovr_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adc_uart_reporter #(.CLK_FREQ(1_000_000), .BAUD(100_000), .REPORT_PERIOD(1000)) u_dut (
    .clk(clk), .reset(reset_a), .enable(enable_a), .adc_data(adc_a),
    .tx(tx_a), .busy(busy_a), .overrun_count(ovr_a)
  );

  adc_uart_reporter #(.CLK_FREQ(1_000_000), .BAUD(100_000), .REPORT_PERIOD(100)) u_dut_ovr (
    .clk(clk), .reset(reset_b), .enable(enable_b), .adc_data(adc_b),
    .tx(tx_b), .busy(busy_b), .overrun_count(ovr_b)
  );

  typedef struct {
    logic [15:0] adc;
    bit          do_chg;
    logic [15:0] chg;
    bit          drop_en;
    logic [55:0] exp;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(logic [15:0] adc, bit do_chg, logic [15:0] chg, bit drop_en,
                              logic [55:0] exp);
    vec_t v;
    v.adc = adc; v.do_chg = do_chg; v.chg = chg; v.drop_en = drop_en; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Watch one frame of instance A from the current negedge; times are in negedges.
  task automatic run_frame(input string name, input int exp_busy_at, input bit do_chg,
                           input logic [15:0] chg, input bit drop_en, input logic [55:0] exp);
    int n = 0, t_busy = -1, t_start = -1, t_end = -1, rel, bi, bj, ferr = 0;
    logic [55:0] got = '0;
    while (t_end < 0 && n < 3000) begin
      @(negedge clk);
      n++;
      if (t_busy < 0 && busy_a) t_busy = n;
      if (t_busy >= 0 && t_start < 0 && !tx_a) t_start = n;
      if (t_busy >= 0 && t_end < 0 && !busy_a) t_end = n;
      if (t_start >= 0 && t_end < 0) begin
        rel = n - t_start;
        if (rel < 700 && rel % 10 == 5) begin
          bi = rel / 100;
          bj = (rel % 100) / 10;
          if (bj == 0)      begin if (tx_a)  ferr++; end
          else if (bj == 9) begin if (!tx_a) ferr++; end
          else got[8*(6-bi) + bj - 1] = tx_a;
        end
        if (do_chg && rel == 250) adc_a = chg;
        if (drop_en && rel == 150) enable_a = 1'b0;
      end
    end
    chk({name, "_done"}, 64'(t_end > 0), 64'd1);
    if (exp_busy_at > 0) chk({name, "_busy_at"}, 64'(t_busy), 64'(exp_busy_at));
    chk({name, "_start_lat"}, 64'(t_start - t_busy), 64'd17);
    chk({name, "_busy_len"}, 64'(t_end - t_busy), 64'd717);
    chk({name, "_framing"}, 64'(ferr), 64'd0);
    chk({name, "_bytes"}, 64'(got), 64'(exp));
    chk({name, "_tx_idle"}, 64'(tx_a), 64'd1);
  endtask

  initial begin
    int idle_bad, w, busy_mis, acc, movr, c;
    bit have, mb;

    vecs[0] = mk(16'd12345, 0, 16'd0,   0, {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h0D, 8'h0A});
    vecs[1] = mk(16'd0,     0, 16'd0,   0, {8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A});
    vecs[2] = mk(16'd65535, 0, 16'd0,   0, {8'h36, 8'h35, 8'h35, 8'h33, 8'h35, 8'h0D, 8'h0A});
    vecs[3] = mk(16'd100,   1, 16'd200, 0, {8'h30, 8'h30, 8'h31, 8'h30, 8'h30, 8'h0D, 8'h0A});
    vecs[4] = mk(16'd200,   0, 16'd0,   0, {8'h30, 8'h30, 8'h32, 8'h30, 8'h30, 8'h0D, 8'h0A});
    vecs[5] = mk(16'd9,     0, 16'd0,   0, {8'h30, 8'h30, 8'h30, 8'h30, 8'h39, 8'h0D, 8'h0A});
    vecs[6] = mk(16'd40960, 0, 16'd0,   0, {8'h34, 8'h30, 8'h39, 8'h36, 8'h30, 8'h0D, 8'h0A});
    vecs[7] = mk(16'd10010, 0, 16'd0,   1, {8'h31, 8'h30, 8'h30, 8'h31, 8'h30, 8'h0D, 8'h0A});

    reset_a = 1'b0; enable_a = 1'b1; adc_a = 16'd12345;
    reset_b = 1'b0; enable_b = 1'b1; adc_b = 16'd5;
    repeat (3) @(negedge clk);
    chk("rst_tx", 64'(tx_a), 64'd1);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_ovr", 64'(ovr_a), 64'd0);
    chk("rst_b_tx", 64'(tx_b), 64'd1);
    reset_a = 1'b1;

    for (int i = 0; i < 8; i++) begin
      adc_a = vecs[i].adc;
      run_frame($sformatf("vec%0d", i), (i == 0) ? 1000 : 0, vecs[i].do_chg, vecs[i].chg,
                vecs[i].drop_en, vecs[i].exp);
    end

    // Enable was dropped mid-frame in the last vector: no ticks while held low.
    idle_bad = 0;
    repeat (5000) begin
      @(negedge clk);
      if (busy_a || !tx_a) idle_bad++;
    end
    chk("en_hold_idle", 64'(idle_bad), 64'd0);
    enable_a = 1'b1;
    adc_a = 16'd54321;
    run_frame("en_rise", 1000, 0, 16'd0, 0, {8'h35, 8'h34, 8'h33, 8'h32, 8'h31, 8'h0D, 8'h0A});

    // Reset pulse in the middle of data bit 2 of the first byte ("1" = 0x31, bit 2 = 0).
    adc_a = 16'd12345;
    w = 0;
    while (!busy_a && w < 1100) begin
      @(negedge clk);
      w++;
    end
    chk("mid_wait_busy", 64'(busy_a), 64'd1);
    repeat (51) @(negedge clk);
    chk("pre_rst_tx", 64'(tx_a), 64'd0);
    reset_a = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx", 64'(tx_a), 64'd1);
    chk("mid_rst_busy", 64'(busy_a), 64'd0);
    chk("mid_rst_ovr", 64'(ovr_a), 64'd0);
    reset_a = 1'b1;
    adc_a = 16'd777;
    run_frame("post_rst", 1000, 0, 16'd0, 0, {8'h30, 8'h30, 8'h37, 8'h37, 8'h37, 8'h0D, 8'h0A});

    // Overrun: ticks every 100 cycles against a 717-cycle busy window.
    reset_b = 1'b1;
    have = 0; acc = 0; movr = 0; busy_mis = 0;
    for (int n = 1; n <= 35000; n++) begin
      @(negedge clk);
      c = n - 1;
      if (c % 100 == 99) begin
        if (have && c >= acc + 1 && c <= acc + 717) begin
          if (movr < 255) movr++;
        end else begin
          have = 1;
          acc = c;
        end
      end
      mb = have && n >= acc + 1 && n <= acc + 717;
      if (busy_b !== mb) busy_mis++;
      if (n == 1000) chk("ovr_at_1000", 64'(ovr_b), 64'(movr));
    end
    chk("ovr_busy_track", 64'(busy_mis), 64'd0);
    chk("ovr_model", 64'(ovr_b), 64'(movr));
    chk("ovr_saturated", 64'(ovr_b), 64'd255);
    reset_b = 1'b0;
    @(negedge clk);
    chk("ovr_rst_clear", 64'(ovr_b), 64'd0);
    chk("ovr_rst_busy", 64'(busy_b), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
